// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one every two cycles,
// using a registered SubWord stage (s4_subword) that evaluates RotWord(w3) each cycle.

module s4_subword (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 via repeated squaring; 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] sub_d;

    always_comb begin
        sub_d = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                 sbox(word_i[15:8]),  sbox(word_i[7:0])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_o <= 32'h0;
        else        word_o <= sub_d;
    end

endmodule

module key_schedule_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, KEY, SUB} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;

    logic [31:0]  rot_w3;
    logic [31:0]  t;
    logic [7:0]   rcon_nxt;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    assign rot_w3 = {key_q[23:0], key_q[31:24]};

    s4_subword u_s4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .word_i (rot_w3),
        .word_o (t)
    );

    // rcon for the round being produced (rnd_q + 1).
    always_comb begin
        case (rnd_q)
            4'd0:    rcon_nxt = 8'h01;
            4'd1:    rcon_nxt = 8'h02;
            4'd2:    rcon_nxt = 8'h04;
            4'd3:    rcon_nxt = 8'h08;
            4'd4:    rcon_nxt = 8'h10;
            4'd5:    rcon_nxt = 8'h20;
            4'd6:    rcon_nxt = 8'h40;
            4'd7:    rcon_nxt = 8'h80;
            4'd8:    rcon_nxt = 8'h1b;
            4'd9:    rcon_nxt = 8'h36;
            default: rcon_nxt = 8'h00;
        endcase
    end

    assign w0_n = key_q[127:96] ^ t ^ {rcon_nxt, 24'h0};
    assign w1_n = key_q[95:64]  ^ w0_n;
    assign w2_n = key_q[63:32]  ^ w1_n;
    assign w3_n = key_q[31:0]   ^ w2_n;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rnd_d      = rnd_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = KEY;
                    key_d      = key_in;
                    rnd_d      = 4'd0;
                    rk_valid_d = 1'b1;
                end
            end
            KEY: begin
                // The final KEY cycle doubles as an accept slot so a new start lands at E21.
                if (rnd_q == 4'd10) begin
                    if (start) begin
                        key_d      = key_in;
                        rnd_d      = 4'd0;
                        rk_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = SUB;
                end
            end
            SUB: begin
                state_d    = KEY;
                key_d      = {w0_n, w1_n, w2_n, w3_n};
                rnd_d      = rnd_q + 4'd1;
                rk_valid_d = 1'b1;
                done_d     = (rnd_q == 4'd9);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= 128'h0;
            rnd_q      <= 4'd0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rnd_q      <= rnd_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_idx   = rnd_q;
    assign rk_out   = key_q;
    assign done     = done_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Randomized and golden-vector bench for key_schedule_iter against a FIPS-197 style word-array model.
module tb_key_schedule_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    key_schedule_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [7:0]   sbox_tbl [0:255];
    logic [7:0]   rcon_tbl [1:10];
    logic [127:0] ref_rk   [0:10];
    logic [127:0] obs      [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sbox_tbl[a] = s;
        end
        rcon_tbl[1] = 8'h01; rcon_tbl[2] = 8'h02; rcon_tbl[3] = 8'h04;
        rcon_tbl[4] = 8'h08; rcon_tbl[5] = 8'h10; rcon_tbl[6] = 8'h20;
        rcon_tbl[7] = 8'h40; rcon_tbl[8] = 8'h80; rcon_tbl[9] = 8'h1b;
        rcon_tbl[10] = 8'h36;
    endtask

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]],
                       sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]]};
                tmp = tmp ^ {rcon_tbl[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) if (done) done_cnt++;

    // Called at a negedge; the next posedge is E0. Returns at the negedge after E20
    // (or after an abort when abort_k >= 0).
    task automatic run_seq(input logic [127:0] key, input bit hold, input int abort_k);
        build_ref(key);
        start  = 1'b1;
        key_in = key;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("k%0d busy", k), 128'(busy), 128'(1'b1));
            chk($sformatf("k%0d valid", k), 128'(rk_valid), 128'((k % 2) == 0));
            chk($sformatf("k%0d idx", k), 128'(rk_idx), 128'(k / 2));
            chk($sformatf("k%0d key", k), rk_out, ref_rk[k / 2]);
            chk($sformatf("k%0d done", k), 128'(done), 128'(k == 20));
            if ((k % 2) == 0) obs[k / 2] = rk_out;
            if (hold) begin
                start  = 1'b1;
                key_in = rand_key();
            end else begin
                start  = 1'b0;
                key_in = rand_key();
            end
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                chk("abort outs", {busy, rk_valid, done, rk_idx, rk_out}, 128'h0);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("abort quiet", {126'h0, rk_valid, busy}, 128'h0);
                end
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_idle(input int cycles, input logic [127:0] last_key);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("idle vld/done/busy", {125'h0, rk_valid, done, busy}, 128'h0);
            chk("idle idx", 128'(rk_idx), 128'd10);
            chk("idle key", rk_out, last_key);
        end
    endtask

    initial begin
        int base;
        logic [127:0] k2;
        build_sbox();

        #12;
        chk("reset outs", {busy, rk_valid, done, rk_idx, rk_out}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(FIPS_KEY, 1'b0, -1);
        chk("fips idx0", obs[0], FIPS_KEY);
        chk("fips idx1", obs[1], FIPS_K1);
        chk("fips idx10", obs[10], FIPS_K10);
        check_idle(50, FIPS_K10);

        run_seq(128'h0, 1'b0, -1);
        chk("zero idx1", obs[1], ZERO_K1);
        chk("zero idx10", obs[10], ZERO_K10);
        check_idle(2, ZERO_K10);

        run_seq(rand_key(), 1'b1, -1);
        k2 = rand_key();
        run_seq(k2, 1'b0, -1);
        chk("hold second idx0", obs[0], k2);
        check_idle(2, ref_rk[10]);

        run_seq(FIPS_KEY, 1'b0, 7);
        @(negedge clk);
        run_seq(FIPS_KEY, 1'b0, -1);
        chk("post-reset idx10", obs[10], FIPS_K10);
        check_idle(2, FIPS_K10);

        base = done_cnt;
        run_seq(FIPS_KEY, 1'b0, -1);
        chk("b2b fips idx10", obs[10], FIPS_K10);
        run_seq(128'h0, 1'b0, -1);
        chk("b2b zero idx10", obs[10], ZERO_K10);
        check_idle(3, ZERO_K10);
        chk("b2b done count", 128'(done_cnt - base), 128'd2);

        for (int r = 0; r < 4; r++) begin
            run_seq(rand_key(), 1'b0, -1);
            check_idle(1 + r, ref_rk[10]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
